// File: rtl/ext_mem_wait_ctrl.sv
// rtl/ext_mem_wait_ctrl.sv - wait-state controller for external program/data memory accesses
// Freezes the pipeline via stall while a request/ack handshake runs against the external region.
module ext_mem_wait_ctrl #(
  parameter int WAIT_PM = 2,
  parameter int WAIT_DM = 3,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pm_add,
  input  logic        pm_req,
  input  logic [15:0] dm_add,
  input  logic        dm_req,
  input  logic        rwb,
  input  logic        ext_ack,
  input  logic [15:0] ext_rdata,
  output logic        stall,
  output logic        ext_req,
  output logic [15:0] ext_add,
  output logic        ext_rwb,
  output logic [15:0] pm_rdata,
  output logic [15:0] dm_rdata,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DM_ACC,
    S_PM_ACC,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_PM_LAST  = 8'(WAIT_PM - 1);
  localparam logic [7:0] LP_DM_LAST  = 8'(WAIT_DM - 1);
  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_pm_pend;
  logic        r_ext_req;
  logic [15:0] r_ext_add;
  logic        r_ext_rwb;
  logic [15:0] r_pm_rdata;
  logic [15:0] r_dm_rdata;
  logic        r_err;

  logic        w_pm_hit;
  logic        w_dm_hit;
  logic        w_in_dm;
  logic [7:0]  w_last;
  logic        w_done;
  logic        w_tmo;

  assign w_pm_hit = pm_req & (pm_add[15:12] != 4'h0);
  assign w_dm_hit = dm_req & (dm_add[15:12] != 4'h0);
  assign w_in_dm  = (r_state == S_DM_ACC);
  assign w_last   = w_in_dm ? LP_DM_LAST : LP_PM_LAST;
  // An ack before the minimum wait has elapsed is deliberately ignored.
  assign w_done   = (r_cnt >= w_last) & ext_ack;
  assign w_tmo    = (r_cnt == LP_TMO_LAST) & ~w_done;

  assign ext_req  = r_ext_req;
  assign ext_add  = r_ext_add;
  assign ext_rwb  = r_ext_rwb;
  assign pm_rdata = r_pm_rdata;
  assign dm_rdata = r_dm_rdata;
  assign err      = r_err;

  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:  stall = ~(w_pm_hit | w_dm_hit);
        S_DONE:  stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_pm_pend  <= 1'b0;
      r_ext_req  <= 1'b0;
      r_ext_add  <= 16'h0000;
      r_ext_rwb  <= 1'b1;
      r_pm_rdata <= 16'h0000;
      r_dm_rdata <= 16'h0000;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Data access first: it belongs to the older instruction.
          if (w_dm_hit) begin
            r_state   <= S_DM_ACC;
            r_ext_add <= dm_add;
            r_ext_rwb <= rwb;
            r_pm_pend <= w_pm_hit;
            r_ext_req <= 1'b1;
            r_cnt     <= 8'd0;
          end else if (w_pm_hit) begin
            r_state   <= S_PM_ACC;
            r_ext_add <= pm_add;
            r_ext_rwb <= 1'b1;
            r_ext_req <= 1'b1;
            r_cnt     <= 8'd0;
          end
        end
        S_DM_ACC, S_PM_ACC: begin
          if (w_done || w_tmo) begin
            if (w_tmo) begin
              r_err <= 1'b1;
            end else if (r_ext_rwb) begin
              if (w_in_dm) r_dm_rdata <= ext_rdata;
              else         r_pm_rdata <= ext_rdata;
            end
            // pm_add is still held by the frozen fetch stage, so re-sample it here.
            if (w_in_dm && r_pm_pend) begin
              r_state   <= S_PM_ACC;
              r_pm_pend <= 1'b0;
              r_ext_add <= pm_add;
              r_ext_rwb <= 1'b1;
              r_cnt     <= 8'd0;
            end else begin
              r_state   <= S_DONE;
              r_ext_req <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_wait_ctrl.sv
// tb/tb_ext_mem_wait_ctrl.sv - scoreboard bench for ext_mem_wait_ctrl
module tb_ext_mem_wait_ctrl;

  localparam int WPM = 2;
  localparam int WDM = 3;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pm_add, dm_add, ext_rdata;
  logic        pm_req, dm_req, rwb, ext_ack;
  logic        stall, ext_req, ext_rwb, err;
  logic [15:0] ext_add, pm_rdata, dm_rdata;

  ext_mem_wait_ctrl #(.WAIT_PM(WPM), .WAIT_DM(WDM), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pm_add(pm_add), .pm_req(pm_req), .dm_add(dm_add),
    .dm_req(dm_req), .rwb(rwb), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .stall(stall), .ext_req(ext_req), .ext_add(ext_add), .ext_rwb(ext_rwb),
    .pm_rdata(pm_rdata), .dm_rdata(dm_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  len;
    logic [15:0] add1;
    logic [15:0] add2;
    logic        rwb1;
    logic [15:0] pmd;
    logic [15:0] dmd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        exp_idle = 1'b0;
  logic [15:0] exp_pm = 16'h0, exp_dm = 16'h0;
  logic        exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ext_addr();
    return {4'($urandom_range(1, 15)), 12'($urandom)};
  endfunction

  function automatic logic [15:0] int_addr();
    return {4'h0, 12'($urandom)};
  endfunction

  // Access length in cycles: ends at the first index >= W-1 with ack high, or at TMO-1.
  function automatic int acc_len(input int w, input int d);
    int c;
    c = (d > w - 1) ? d : w - 1;
    if (c > TMO - 1) c = TMO - 1;
    return c + 1;
  endfunction

  // kind: 0 = DM only, 1 = PM only, 2 = both. d1/d2: ack delay in cycles from the access start.
  task automatic run_txn(input int kind, input logic [15:0] da, input logic [15:0] pa,
                         input logic rw, input int d1, input int d2,
                         input logic fix, input logic [15:0] fixv);
    logic [15:0] rd [0:63];
    int   l1, l2, total;
    exp_t e;
    l1 = acc_len((kind == 1) ? WPM : WDM, d1);
    l2 = (kind == 2) ? acc_len(WPM, d2) : 0;
    total = l1 + l2 + 1;
    for (int i = 0; i < 64; i++) rd[i] = fix ? fixv : 16'($urandom);
    if (d1 > TMO - 1) exp_err = 1'b1;
    else if (kind == 1) exp_pm = rd[l1];
    else if (rw) exp_dm = rd[l1];
    if (kind == 2) begin
      if (d2 > TMO - 1) exp_err = 1'b1;
      else exp_pm = rd[l1 + l2];
    end
    e.len  = 8'(total);
    e.add1 = (kind == 1) ? pa : da;
    e.rwb1 = (kind == 1) ? 1'b1 : rw;
    e.add2 = (kind == 2) ? pa : e.add1;
    e.pmd  = exp_pm;
    e.dmd  = exp_dm;
    e.err  = exp_err;
    sb.push_back(e);
    dm_req    = (kind != 1) ? 1'b1 : 1'($urandom);
    dm_add    = (kind != 1) ? da : int_addr();
    pm_req    = (kind != 0) ? 1'b1 : 1'($urandom);
    pm_add    = (kind != 0) ? pa : int_addr();
    rwb       = rw;
    ext_ack   = 1'($urandom);
    ext_rdata = 16'($urandom);
    for (int c = 1; c <= total; c++) begin
      step();
      if (c <= l1)           ext_ack = ((c - 1) >= d1);
      else if (c <= l1 + l2) ext_ack = ((c - 1 - l1) >= d2);
      else                   ext_ack = 1'($urandom);
      ext_rdata = rd[c];
      dm_add    = ext_addr();
      rwb       = 1'($urandom);
      if (c == total) begin
        pm_req = 1'b1;
        dm_req = 1'b1;
        pm_add = ext_addr();
      end
    end
    step();
    pm_req = 1'b0;
    dm_req = 1'b0;
    pm_add = int_addr();
    dm_add = int_addr();
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic idle_phase(input int n, input logic fixed);
    exp_idle = 1'b1;
    for (int i = 0; i < n; i++) begin
      pm_req  = fixed ? 1'b1 : 1'($urandom);
      dm_req  = fixed ? 1'b1 : 1'($urandom);
      pm_add  = fixed ? 16'h0123 : int_addr();
      dm_add  = fixed ? 16'h0FFF : int_addr();
      ext_ack = 1'($urandom);
      step();
    end
    exp_idle = 1'b0;
    pm_req = 1'b0;
    dm_req = 1'b0;
  endtask

  int          run_len = 0, req_low = 0;
  logic        seen = 1'b0, first_rwb;
  logic [15:0] first_add, last_add;
  exp_t        got;

  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
      req_low = 0;
      seen    = 1'b0;
    end else if (exp_idle) begin
      check("idle_stall", {31'd0, stall}, 32'd1);
      check("idle_ext_req", {31'd0, ext_req}, 32'd0);
    end else if (!stall) begin
      run_len++;
      if (ext_req) begin
        if (!seen) begin
          first_add = ext_add;
          first_rwb = ext_rwb;
          seen      = 1'b1;
        end
        last_add = ext_add;
      end else begin
        req_low++;
      end
    end else if (run_len > 0) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: stall run of %0d with nothing expected", run_len);
      end else begin
        got = sb.pop_front();
        check("stall_low_len", run_len, {24'd0, got.len});
        check("req_low_cycles", req_low, 32'd1);
        check("ext_add_first", {16'd0, first_add}, {16'd0, got.add1});
        check("ext_rwb_first", {31'd0, first_rwb}, {31'd0, got.rwb1});
        check("ext_add_last", {16'd0, last_add}, {16'd0, got.add2});
        check("ext_req_done", {31'd0, ext_req}, 32'd0);
        check("pm_rdata", {16'd0, pm_rdata}, {16'd0, got.pmd});
        check("dm_rdata", {16'd0, dm_rdata}, {16'd0, got.dmd});
        check("err", {31'd0, err}, {31'd0, got.err});
      end
      run_len = 0;
      req_low = 0;
      seen    = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    rst = 1'b1;
    pm_req = 1'b0; dm_req = 1'b0; pm_add = 16'h0; dm_add = 16'h0;
    rwb = 1'b1; ext_ack = 1'b0; ext_rdata = 16'h0;
    step();
    step();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ext_req", {31'd0, ext_req}, 32'd0);
    check("rst_ext_add", {16'd0, ext_add}, 32'd0);
    check("rst_ext_rwb", {31'd0, ext_rwb}, 32'd1);
    check("rst_pm_rdata", {16'd0, pm_rdata}, 32'd0);
    check("rst_dm_rdata", {16'd0, dm_rdata}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    step();

    idle_phase(10, 1'b1);
    run_txn(0, 16'h1A1B, 16'h0000, 1'b1, 0, 0, 1'b1, 16'hBEEF);
    run_txn(2, 16'h2FFF, 16'h1FFF, 1'b0, 0, 0, 1'b0, 16'h0);
    run_txn(1, 16'h0000, 16'h3456, 1'b1, 4, 0, 1'b0, 16'h0);
    run_txn(0, 16'h4000, 16'h0000, 1'b1, 100, 0, 1'b0, 16'h0);
    idle_phase(5, 1'b0);

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      run_txn(kind, ext_addr(), ext_addr(), 1'($urandom),
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 30)) : int'($urandom_range(0, 8)),
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 30)) : int'($urandom_range(0, 8)),
              1'b0, 16'h0);
      if (t % 10 == 9) idle_phase(4, 1'b0);
    end

    // Reset in the second PM access cycle.
    pm_add = 16'h5A5A; pm_req = 1'b1; dm_req = 1'b0; ext_ack = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("mid_rst_ext_req", {31'd0, ext_req}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_pm_rdata", {16'd0, pm_rdata}, 32'd0);
    check("mid_rst_dm_rdata", {16'd0, dm_rdata}, 32'd0);
    check("mid_rst_ext_add", {16'd0, ext_add}, 32'd0);
    rst = 1'b0;
    pm_req = 1'b0;
    exp_pm = 16'h0; exp_dm = 16'h0; exp_err = 1'b0;
    #1;
    check("post_rst_stall", {31'd0, stall}, 32'd1);
    run_txn(1, 16'h0000, 16'h6789, 1'b1, 0, 0, 1'b0, 16'h0);
    run_txn(2, 16'h7001, 16'h8002, 1'b1, 2, 5, 1'b0, 16'h0);

    repeat (3) step();
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
